// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch unit: NPC select encodings,
// fetch FSM states and the default boot address.
package pc_fetch_pkg;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_B   = 2'b01;
  localparam logic [1:0] PCSEL_J   = 2'b10;
  localparam logic [1:0] PCSEL_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    IDLE = 2'b01,
    PEND = 2'b10,
    HALT = 2'b11
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read channel: one outstanding request, completed by imem_ready.
interface pc_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit_target_sel.sv
// Selects the redirect target among the NPC candidates and flags a
// target that is not word-aligned.
module pc_target_sel
  import pc_fetch_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_npc4,
  input  logic [31:0] i_npcb,
  input  logic [31:0] i_npcj,
  input  logic [31:0] i_npcjr,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_target (no latch).
    o_target = i_npc4;
    unique case (i_sel)
      PCSEL_PC4: o_target = i_npc4;
      PCSEL_B:   o_target = i_npcb;
      PCSEL_J:   o_target = i_npcj;
      PCSEL_JR:  o_target = i_npcjr;
    endcase
  end

  assign o_misaligned = is_misaligned(o_target);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-outstanding imem reads and
// loads the F/D register; decode closes the loop with pc_sel/redirect_valid.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            npc4,
  input  logic [31:0]            npcb,
  input  logic [31:0]            npcj,
  input  logic [31:0]            npcjr,
  input  logic [1:0]             pc_sel,
  input  logic                   redirect_valid,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            pc_d,
  output logic [31:0]            pc4_d,
  output logic                   addr_err
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_addr;
  logic         r_drop;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic [31:0]  r_pc_d;
  logic [31:0]  r_pc4_d;
  logic         r_addr_err;

  logic [31:0]  w_target;
  logic         w_target_misaligned;
  logic         w_redirect;
  logic         w_consume;
  logic         w_req;
  logic         w_done;
  logic [31:0]  w_pc_plus4;

  pc_target_sel u_target_sel (
    .i_sel        (pc_sel),
    .i_npc4       (npc4),
    .i_npcb       (npcb),
    .i_npcj       (npcj),
    .i_npcjr      (npcjr),
    .o_target     (w_target),
    .o_misaligned (w_target_misaligned)
  );

  // A redirect raised together with stall is treated as a plain stall.
  assign w_redirect = redirect_valid & ~stall & (r_state != HALT);
  assign w_consume  = r_instr_valid & ~stall;
  assign w_pc_plus4 = r_fetch_pc + 32'd4;

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      BOOT: w_req = 1'b0;
      IDLE: w_req = ~redirect_valid & (~r_instr_valid | ~stall);
      PEND: w_req = 1'b1;
      HALT: w_req = 1'b0;
    endcase
  end

  assign w_done = w_req & imem.imem_ready;

  // The outstanding address stays frozen in PEND even after a redirect moves fetch_pc.
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = (r_state == PEND) ? r_req_addr : r_fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_drop        <= 1'b0;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_pc_d        <= 32'd0;
      r_pc4_d       <= 32'd0;
      r_addr_err    <= 1'b0;
    end else begin
      unique case (r_state)
        BOOT: r_state <= IDLE;
        IDLE: begin
          if (w_done) begin
            r_instr       <= imem.imem_rdata;
            r_pc_d        <= r_fetch_pc;
            r_pc4_d       <= w_pc_plus4;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= w_pc_plus4;
          end else if (w_req) begin
            r_state       <= PEND;
            r_req_addr    <= r_fetch_pc;
            r_instr_valid <= 1'b0;
          end else if (w_consume) begin
            r_instr_valid <= 1'b0;
          end
        end
        PEND: begin
          if (imem.imem_ready) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            if (!r_drop && !w_redirect) begin
              r_instr       <= imem.imem_rdata;
              r_pc_d        <= r_fetch_pc;
              r_pc4_d       <= w_pc_plus4;
              r_instr_valid <= 1'b1;
              r_fetch_pc    <= w_pc_plus4;
            end
          end
        end
        HALT: begin
        end
      endcase

      // NOTE: this block comes after the state case so its non-blocking writes win.
      if (w_redirect) begin
        r_instr_valid <= 1'b0;
        if (w_target_misaligned) begin
          r_addr_err <= 1'b1;
          r_state    <= HALT;
          r_drop     <= 1'b0;
        end else begin
          r_fetch_pc <= w_target;
          if (r_state == PEND && !imem.imem_ready) begin
            r_drop <= 1'b1;
          end
        end
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc_d        = r_pc_d;
  assign pc4_d       = r_pc4_d;
  assign addr_err    = r_addr_err;

  a_pend_fd_empty: assert property (
    @(posedge clk) disable iff (!rst_n) (r_state == PEND) |-> !r_instr_valid
  );

  a_no_redirect_on_stall: assert property (
    @(posedge clk) disable iff (!rst_n) !(redirect_valid && stall)
  );

endmodule
